// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, a two-edge
// pipeline-clear sequence after reset, and saturating stall/flush counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        startin_n,
    input  logic [4:0]  ID_instr_25_21,
    input  logic [4:0]  ID_instr_20_16,
    input  logic        ID_uses_rt,
    input  logic        EX_mem_read,
    input  logic [4:0]  EX_instr_20_16,
    input  logic        EX_branch_taken,
    input  logic        cnt_clr,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        init_busy,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        init_cnt_q, init_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        load_use_s;

    // Load-use hazard detection; a load into $0 never creates a dependency.
    always_comb begin
        load_use_s = EX_mem_read
                   & (EX_instr_20_16 != 5'd0)
                   & ((EX_instr_20_16 == ID_instr_25_21)
                      | (ID_uses_rt & (EX_instr_20_16 == ID_instr_20_16)));
    end

    // Next-state, counter update and control output decode.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        init_busy   = 1'b1;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == 1'b1) begin
                    state_d    = ST_RUN;
                    init_cnt_d = 1'b0;
                end else begin
                    init_cnt_d = 1'b1;
                end
            end
            ST_RUN: begin
                init_busy = 1'b0;
                if (EX_branch_taken) begin
                    pc_write    = 1'b1;
                    IF_ID_write = 1'b1;
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                    if (flush_cnt_q != 16'hFFFF) begin
                        flush_cnt_d = flush_cnt_q + 16'd1;
                    end else begin
                        flush_cnt_d = flush_cnt_q;
                    end
                end else if (load_use_s) begin
                    pc_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    IF_ID_flush = 1'b0;
                    ID_EX_flush = 1'b1;
                    if (stall_cnt_q != 16'hFFFF) begin
                        stall_cnt_d = stall_cnt_q + 16'd1;
                    end else begin
                        stall_cnt_d = stall_cnt_q;
                    end
                end else begin
                    pc_write    = 1'b1;
                    IF_ID_write = 1'b1;
                    IF_ID_flush = 1'b0;
                    ID_EX_flush = 1'b0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = 1'b0;
            end
        endcase

        // Clear takes precedence over any increment computed above.
        if (cnt_clr) begin
            stall_cnt_d = 16'd0;
            flush_cnt_d = 16'd0;
        end else begin
            stall_cnt_d = stall_cnt_d;
            flush_cnt_d = flush_cnt_d;
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
